out_step_sequencer: RTL and testbench

- Initiator at the other end of the output-neuron-block handshake.
- Per image: pulses start_core_img, then issues T_STEPS time units. Each time unit is one start_op_nub / valid_op_nub handshake followed by a TU_incre pulse.
- Captures the returned spike vector each time unit and keeps per-neuron saturating spike counts.
- After the last time unit, scans the counts sequentially and reports the winning (classified) neuron to the top-level controller.

---
 rtl/out_step_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_out_step_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_step_sequencer.sv
// out_step_sequencer
// Drives the output-neuron-block handshake for one image at a time. It collects
// per-neuron spike counts over T_STEPS time units, then scans the counts to find
// the winning neuron. Every output comes straight from a flop.
module out_step_sequencer #(
  parameter int N       = 8,
  parameter int CW      = 8,
  parameter int T_STEPS = 350,
  parameter int SW      = 10,
  parameter int IW      = 3,
  parameter int TO_CYC  = 1023
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            img_start,
  input  logic            valid_op_nub,
  input  logic [N-1:0]    spike_op_nub,
  output logic            start_core_img,
  output logic            start_op_nub,
  output logic            TU_incre,
  output logic            busy,
  output logic            img_done,
  output logic [IW-1:0]   winner,
  output logic            no_spike,
  output logic            timeout_err,
  output logic [N*CW-1:0] spike_count
);

  localparam int TW = $clog2(TO_CYC + 1);

  typedef enum logic [2:0] {IDLE, INIT, ISSUE, WAIT, TU, ARGMAX, DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] best_cnt_q, best_cnt_d;
  logic [IW-1:0] best_idx_q, best_idx_d;
  logic [IW-1:0] winner_q, winner_d;
  logic          no_spike_q, no_spike_d;
  logic          timeout_err_q, timeout_err_d;
  logic          start_core_img_q, start_core_img_d;
  logic          start_op_nub_q, start_op_nub_d;
  logic          tu_incre_q, tu_incre_d;
  logic          busy_q, busy_d;
  logic          img_done_q, img_done_d;

  logic [CW-1:0] cand_cnt;
  logic          cand_wins;
  logic [CW-1:0] new_best_cnt;
  logic [IW-1:0] new_best_idx;
  logic          last_idx;
  logic          to_expire;

  // Scan helpers: pick the candidate count, decide if it beats the running best, detect WAIT expiry
  always_comb begin
    cand_cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) cand_cnt = cnt_q[i];
    end
    cand_wins    = (idx_q == '0) || (cand_cnt > best_cnt_q);
    new_best_cnt = cand_wins ? cand_cnt : best_cnt_q;
    new_best_idx = cand_wins ? idx_q : best_idx_q;
    last_idx     = (idx_q == IW'(N - 1));
    to_expire    = (state_q == WAIT) && !valid_op_nub &&
                   ((to_cnt_q + TW'(1)) == TW'(TO_CYC));
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic for the per-image sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (img_start) state_d = INIT;
      INIT:    state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (valid_op_nub)   state_d = TU;
        else if (to_expire) state_d = IDLE;
      end
      TU:      state_d = (step_q == SW'(T_STEPS)) ? ARGMAX : ISSUE;
      ARGMAX:  if (last_idx) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output pulses are decoded from the state being entered, so they appear as flops in that state
  always_comb begin
    start_core_img_d = (state_d == INIT);
    start_op_nub_d   = (state_d == ISSUE);
    tu_incre_d       = (state_d == TU);
    busy_d           = (state_d != IDLE);
    img_done_d       = (state_d == DONE);
  end

  // Datapath: spike counters, step and timeout counters, argmax scan and result capture
  always_comb begin
    step_d        = step_q;
    to_cnt_d      = to_cnt_q;
    idx_d         = '0;
    best_cnt_d    = best_cnt_q;
    best_idx_d    = best_idx_q;
    winner_d      = winner_q;
    no_spike_d    = no_spike_q;
    timeout_err_d = timeout_err_q;
    for (int i = 0; i < N; i++) cnt_d[i] = cnt_q[i];
    case (state_q)
      IDLE: begin
        if (img_start) begin
          step_d        = '0;
          timeout_err_d = 1'b0;
          winner_d      = '0;
          no_spike_d    = 1'b0;
          for (int i = 0; i < N; i++) cnt_d[i] = '0;
        end
      end
      ISSUE: to_cnt_d = '0;
      WAIT: begin
        if (valid_op_nub) begin
          step_d = step_q + SW'(1);
          for (int i = 0; i < N; i++) begin
            if (spike_op_nub[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
          if (to_expire) timeout_err_d = 1'b1;
        end
      end
      ARGMAX: begin
        best_cnt_d = new_best_cnt;
        best_idx_d = new_best_idx;
        if (last_idx) begin
          winner_d   = new_best_idx;
          no_spike_d = (new_best_cnt == '0);
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers, all cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q           <= '0;
      to_cnt_q         <= '0;
      idx_q            <= '0;
      best_cnt_q       <= '0;
      best_idx_q       <= '0;
      winner_q         <= '0;
      no_spike_q       <= 1'b0;
      timeout_err_q    <= 1'b0;
      start_core_img_q <= 1'b0;
      start_op_nub_q   <= 1'b0;
      tu_incre_q       <= 1'b0;
      busy_q           <= 1'b0;
      img_done_q       <= 1'b0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      step_q           <= step_d;
      to_cnt_q         <= to_cnt_d;
      idx_q            <= idx_d;
      best_cnt_q       <= best_cnt_d;
      best_idx_q       <= best_idx_d;
      winner_q         <= winner_d;
      no_spike_q       <= no_spike_d;
      timeout_err_q    <= timeout_err_d;
      start_core_img_q <= start_core_img_d;
      start_op_nub_q   <= start_op_nub_d;
      tu_incre_q       <= tu_incre_d;
      busy_q           <= busy_d;
      img_done_q       <= img_done_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign start_core_img = start_core_img_q;
  assign start_op_nub   = start_op_nub_q;
  assign TU_incre       = tu_incre_q;
  assign busy           = busy_q;
  assign img_done       = img_done_q;
  assign winner         = winner_q;
  assign no_spike       = no_spike_q;
  assign timeout_err    = timeout_err_q;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign spike_count[g*CW +: CW] = cnt_q[g];
  end

endmodule

// File: tb/tb_out_step_sequencer.sv
// tb_out_step_sequencer
// Two sequencer instances share clock and reset. Instance A is a 4-neuron,
// 3-step build with a short timeout. Instance B uses 2-bit counters and 5 steps,
// so its counters can saturate. The bench acts as the output neuron block and
// answers each start_op_nub two cycles later.
module tb_out_step_sequencer;

  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int A_CW = 8;
  localparam int A_T  = 3;
  localparam int A_TO = 15;
  localparam int B_CW = 2;
  localparam int B_T  = 5;
  localparam int B_TO = 15;
  localparam int DLY  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // Shared stimulus, steered to whichever instance is selected
  logic         selB = 1'b0;
  logic         dImgStart = 1'b0;
  logic         dValid = 1'b0;
  logic [N-1:0] dSpike = '0;

  logic aImgStart, aValid, bImgStart, bValid;
  logic [N-1:0] aSpike, bSpike;
  logic aCore, aOp, aTu, aBusy, aDone, aNoSpike, aTerr;
  logic bCore, bOp, bTu, bBusy, bDone, bNoSpike, bTerr;
  logic [IW-1:0] aWinner, bWinner;
  logic [N*A_CW-1:0] aCounts;
  logic [N*B_CW-1:0] bCounts;

  assign aImgStart = selB ? 1'b0 : dImgStart;
  assign aValid    = selB ? 1'b0 : dValid;
  assign aSpike    = selB ? '0 : dSpike;
  assign bImgStart = selB ? dImgStart : 1'b0;
  assign bValid    = selB ? dValid : 1'b0;
  assign bSpike    = selB ? dSpike : '0;

  // Observed outputs of the selected instance
  logic oCore, oOp, oTu, oBusy, oDone, oNoSpike, oTerr;
  logic [IW-1:0] oWinner;
  logic [31:0] oCounts;

  assign oCore    = selB ? bCore : aCore;
  assign oOp      = selB ? bOp : aOp;
  assign oTu      = selB ? bTu : aTu;
  assign oBusy    = selB ? bBusy : aBusy;
  assign oDone    = selB ? bDone : aDone;
  assign oNoSpike = selB ? bNoSpike : aNoSpike;
  assign oTerr    = selB ? bTerr : aTerr;
  assign oWinner  = selB ? bWinner : aWinner;
  assign oCounts  = selB ? 32'(bCounts) : 32'(aCounts);

  out_step_sequencer #(
    .N(N), .CW(A_CW), .T_STEPS(A_T), .SW(4), .IW(IW), .TO_CYC(A_TO)
  ) dutA (
    .clk(clk), .rst(rst), .img_start(aImgStart), .valid_op_nub(aValid),
    .spike_op_nub(aSpike), .start_core_img(aCore), .start_op_nub(aOp),
    .TU_incre(aTu), .busy(aBusy), .img_done(aDone), .winner(aWinner),
    .no_spike(aNoSpike), .timeout_err(aTerr), .spike_count(aCounts)
  );

  out_step_sequencer #(
    .N(N), .CW(B_CW), .T_STEPS(B_T), .SW(3), .IW(IW), .TO_CYC(B_TO)
  ) dutB (
    .clk(clk), .rst(rst), .img_start(bImgStart), .valid_op_nub(bValid),
    .spike_op_nub(bSpike), .start_core_img(bCore), .start_op_nub(bOp),
    .TU_incre(bTu), .busy(bBusy), .img_done(bDone), .winner(bWinner),
    .no_spike(bNoSpike), .timeout_err(bTerr), .spike_count(bCounts)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  typedef struct {
    int          winner;
    bit          noSpike;
    int          latency;
    logic [31:0] counts;
  } exp_t;

  exp_t sb[$];
  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  // Single comparison point: counts the check and reports any disagreement
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one full image on the selected instance. The expected result is pushed
  // to the scoreboard, and the bench plays the neuron block, returning pattern
  // step s as pat[s*N +: N]. extraStartAt (non-zero) pulses img_start in that
  // cycle while the sequencer is busy; it must be ignored.
  task automatic applyStimulus(input bit useB, input logic [31:0] pat, input int extraStartAt);
    int   cw, tSteps, maxv, best;
    int   cnt[N];
    exp_t e;
    exp_t got;
    int   cyc, coreN, opN, tuN, lastTu, gapErr, countdown, stepIdx, doneCyc;
    logic errAtInit;
    cw     = useB ? B_CW : A_CW;
    tSteps = useB ? B_T : A_T;
    maxv   = (1 << cw) - 1;
    foreach (cnt[i]) cnt[i] = 0;
    for (int s = 0; s < tSteps; s++)
      for (int i = 0; i < N; i++)
        if (pat[s*N + i] && cnt[i] < maxv) cnt[i]++;
    best = cnt[0];
    e.winner = 0;
    for (int i = 1; i < N; i++)
      if (cnt[i] > best) begin best = cnt[i]; e.winner = i; end
    e.noSpike = (best == 0);
    e.latency = 1 + tSteps * (2 + DLY) + N + 1;
    e.counts  = '0;
    for (int i = 0; i < N; i++) e.counts |= 32'(cnt[i]) << (i * cw);
    sb.push_back(e);

    selB = useB;
    got = '{default: 0};
    cyc = 0; coreN = 0; opN = 0; tuN = 0; lastTu = -10; gapErr = 0;
    countdown = 0; stepIdx = 0; doneCyc = -1; errAtInit = 1'bx;
    @(negedge clk);
    dImgStart = 1'b1;
    while (doneCyc < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      dImgStart = (cyc == extraStartAt);
      dValid = 1'b0;
      dSpike = '0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          dValid = 1'b1;
          dSpike = pat[stepIdx*N +: N];
          stepIdx++;
        end
      end
      if (cyc == 1) errAtInit = oTerr;
      if (oCore) coreN++;
      if (oOp) begin
        opN++;
        countdown = DLY;
        if (opN > 1 && cyc != lastTu + 1) gapErr++;
      end
      if (oTu) begin
        tuN++;
        lastTu = cyc;
      end
      if (oDone) begin
        doneCyc     = cyc;
        got.winner  = int'(oWinner);
        got.noSpike = oNoSpike;
        got.counts  = oCounts;
      end
    end
    dImgStart = 1'b0;

    e = sb.pop_front();
    checkOutput("done_seen", 32'(doneCyc >= 0), 32'd1);
    checkOutput("done_latency", 32'(doneCyc), 32'(e.latency));
    checkOutput("winner", 32'(got.winner), 32'(e.winner));
    checkOutput("no_spike", 32'(got.noSpike), 32'(e.noSpike));
    checkOutput("spike_count", got.counts, e.counts);
    checkOutput("core_pulses", 32'(coreN), 32'd1);
    checkOutput("op_pulses", 32'(opN), 32'(tSteps));
    checkOutput("tu_pulses", 32'(tuN), 32'(tSteps));
    checkOutput("tu_to_op_gap", 32'(gapErr), 32'd0);
    checkOutput("terr_cleared_at_init", 32'(errAtInit), 32'd0);
    @(negedge clk);
    checkOutput("idle_after_done", {30'd0, oBusy, oDone}, 32'd0);
    checkOutput("winner_held", 32'(oWinner), 32'(e.winner));
  endtask

  // A valid pulse while idle must not touch the held counts
  task automatic idleValid(input logic [31:0] expCounts);
    selB = 1'b0;
    @(negedge clk);
    dValid = 1'b1;
    dSpike = '1;
    @(negedge clk);
    dValid = 1'b0;
    dSpike = '0;
    @(negedge clk);
    checkOutput("idle_valid_ignored", oCounts, expCounts);
    checkOutput("idle_valid_no_busy", 32'(oBusy), 32'd0);
  endtask

  // The neuron block never answers: the sequencer must give up after A_TO WAIT cycles
  task automatic timeoutRun();
    int cyc = 0;
    int idleCyc = -1;
    int doneN = 0;
    selB = 1'b0;
    @(negedge clk);
    dImgStart = 1'b1;
    while (idleCyc < 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      dImgStart = 1'b0;
      if (oDone) doneN++;
      if (cyc > 1 && !oBusy) idleCyc = cyc;
    end
    checkOutput("timeout_idle_cycle", 32'(idleCyc), 32'(2 + A_TO + 1));
    checkOutput("timeout_err_set", 32'(oTerr), 32'd1);
    checkOutput("timeout_no_done", 32'(doneN), 32'd0);
    checkOutput("timeout_counts_cleared", oCounts, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("timeout_err_sticky", 32'(oTerr), 32'd1);
  endtask

  // Reset lands in the WAIT of the second time unit; everything must clear at once
  task automatic resetDuringWait();
    int cyc = 0;
    int opN = 0;
    int countdown = 0;
    int doneN = 0;
    int busyN = 0;
    bit aborted = 1'b0;
    selB = 1'b0;
    @(negedge clk);
    dImgStart = 1'b1;
    while (!aborted && cyc < 100) begin
      @(negedge clk);
      cyc++;
      dImgStart = 1'b0;
      dValid = 1'b0;
      dSpike = '0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          dValid = 1'b1;
          dSpike = '1;
        end
      end
      if (oOp) begin
        opN++;
        countdown = DLY;
      end else if (opN == 2) begin
        checkOutput("pre_reset_counts", oCounts, 32'h0101_0101);
        dValid = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_flags",
                    {25'd0, oCore, oOp, oTu, oBusy, oDone, oNoSpike, oTerr}, 32'd0);
        checkOutput("async_reset_counts", oCounts, 32'd0);
        checkOutput("async_reset_winner", 32'(oWinner), 32'd0);
        aborted = 1'b1;
      end
    end
    checkOutput("abort_reached", 32'(aborted), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (oDone) doneN++;
      if (oBusy) busyN++;
    end
    checkOutput("abort_no_done", 32'(doneN), 32'd0);
    checkOutput("abort_stays_idle", 32'(busyN), 32'd0);
  endtask

  // Directed sequence of scenarios followed by the summary line
  initial begin
    $display("[TB] out_step_sequencer bench starting");
    repeat (3) @(negedge clk);
    checkOutput("reset_flags_a",
                {25'd0, aCore, aOp, aTu, aBusy, aDone, aNoSpike, aTerr}, 32'd0);
    checkOutput("reset_counts_a", 32'(aCounts), 32'd0);
    checkOutput("reset_winner_a", 32'(aWinner), 32'd0);
    checkOutput("reset_flags_b",
                {24'd0, bCore, bOp, bTu, bBusy, bDone, bNoSpike, bTerr, 1'b0}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] neuron 1 spikes every step");
    applyStimulus(1'b0, 32'h0000_0222, 0);
    $display("[TB] no spikes at all");
    applyStimulus(1'b0, 32'h0000_0000, 0);
    $display("[TB] tie between neurons 2 and 3");
    applyStimulus(1'b0, 32'h0000_08C4, 0);
    idleValid(32'h0202_0000);
    $display("[TB] highest index wins");
    applyStimulus(1'b0, 32'h0000_0898, 0);

    $display("[TB] timeout with silent neuron block");
    timeoutRun();
    applyStimulus(1'b0, 32'h0000_0888, 0);

    $display("[TB] reset in the middle of step 2");
    resetDuringWait();
    applyStimulus(1'b0, 32'h0000_0444, 5);

    $display("[TB] saturating 2-bit counters");
    applyStimulus(1'b1, 32'h0001_1133, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
